// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port between NREQ producers
module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 32,
    parameter int MAX_BURST = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*DW-1:0]       data,
    output logic [NREQ-1:0]          ack,
    output logic                     fifo_wr,
    output logic [DW-1:0]            fifo_wdata,
    input  logic                     fifo_full,
    output logic [$clog2(NREQ)-1:0]  grant_id,
    output logic                     busy
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST) + 1;

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IW-1:0]   last_ptr;
    logic [IW-1:0]   last_ptr_nxt;
    logic [IW-1:0]   grant_nxt;
    logic [CW-1:0]   beat_cnt;
    logic [CW-1:0]   beat_nxt;
    logic [IW-1:0]   pick;
    logic            pick_vld;
    logic [IW-1:0]   scan_idx;

    // Round-robin scan: walk from farthest to nearest after last_ptr so the nearest requester wins.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        scan_idx = '0;
        for (int k = NREQ; k >= 1; k--) begin
            scan_idx = last_ptr + IW'(k);
            if (req[scan_idx]) begin
                pick     = scan_idx;
                pick_vld = 1'b1;
            end
        end
    end

    // Write port and handshake outputs depend only on registered state plus live req/full.
    always_comb begin
        busy       = (state == BURST);
        fifo_wr    = busy & req[grant_id] & ~fifo_full;
        ack        = fifo_wr ? (NREQ'(1) << grant_id) : '0;
        fifo_wdata = busy ? data[int'(grant_id)*DW +: DW] : '0;
    end

    // Next-state: grant in IDLE, count beats in BURST, leave on burst end or dropped request.
    always_comb begin
        state_nxt    = state;
        grant_nxt    = grant_id;
        last_ptr_nxt = last_ptr;
        beat_nxt     = beat_cnt;
        case (state)
            IDLE: begin
                if (pick_vld) begin
                    grant_nxt    = pick;
                    last_ptr_nxt = pick;
                    beat_nxt     = '0;
                    state_nxt    = BURST;
                end
            end
            BURST: begin
                if (!req[grant_id]) begin
                    state_nxt = IDLE;
                end else if (fifo_wr) begin
                    beat_nxt = beat_cnt + CW'(1);
                    if (beat_cnt == CW'(MAX_BURST - 1)) begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register; requester 0 gets first priority after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= '0;
            last_ptr <= IW'(NREQ - 1);
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            grant_id <= grant_nxt;
            last_ptr <= last_ptr_nxt;
            beat_cnt <= beat_nxt;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed and random scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int NREQ      = 4;
    localparam int DW        = 32;
    localparam int MAX_BURST = 4;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ*DW-1:0] data = '0;
    logic [NREQ-1:0]    ack;
    logic               fifo_wr;
    logic [DW-1:0]      fifo_wdata;
    logic               fifo_full = 1'b0;
    logic [1:0]         grant_id;
    logic               busy;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q [NREQ][$];
    int            remaining [NREQ];
    int            seq [NREQ];
    int            cyc_log [$];
    int            wr_log [$];

    fifo_wr_arbiter #(
        .NREQ      (NREQ),
        .DW        (DW),
        .MAX_BURST (MAX_BURST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data       (data),
        .ack        (ack),
        .fifo_wr    (fifo_wr),
        .fifo_wdata (fifo_wdata),
        .fifo_full  (fifo_full),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic present(input int i);
        logic [DW-1:0] w;
        w = {8'(i), 24'(seq[i])};
        seq[i]++;
        remaining[i]--;
        data[i*DW +: DW] = w;
        req[i] = 1'b1;
        exp_q[i].push_back(w);
    endtask

    task automatic tick();
        logic [NREQ-1:0] xfer;
        logic [DW-1:0]   e;
        int              id;
        @(negedge clk);
        chk("ack_onehot0", 64'($onehot0(ack)), 64'(1));
        chk("wr_eq_any_ack", 64'(fifo_wr), 64'(|ack));
        chk("ack_when_full", 64'(fifo_full && (ack != '0)), 64'(0));
        xfer = req & ack;
        id = -1;
        for (int i = 0; i < NREQ; i++) begin
            if (ack[i]) id = i;
        end
        if (fifo_wr && id >= 0) begin
            chk("grant_id_vs_ack", 64'(grant_id), 64'(id));
            chk("write_has_expected", 64'(exp_q[id].size() != 0), 64'(1));
            if (exp_q[id].size() != 0) begin
                e = exp_q[id].pop_front();
                chk("fifo_wdata", 64'(fifo_wdata), 64'(e));
            end
            wr_log.push_back(id);
        end
        cyc_log.push_back(fifo_wr ? id : -1);
        @(posedge clk);
        #1;
        for (int i = 0; i < NREQ; i++) begin
            if (xfer[i]) begin
                req[i] = 1'b0;
                if (remaining[i] > 0) present(i);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '1;
        fifo_full = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            exp_q[i].delete();
            remaining[i] = 0;
        end
        #1;
        chk("rst_ack", 64'(ack), 64'(0));
        chk("rst_fifo_wr", 64'(fifo_wr), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_wdata", 64'(fifo_wdata), 64'(0));
        chk("rst_grant_id", 64'(grant_id), 64'(0));
        @(posedge clk);
        #1;
        req  = '0;
        data = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc_log.delete();
        wr_log.delete();
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((req != '0 || busy) && k < budget) begin
            tick();
            k++;
        end
        chk("drain_done", 64'(req != '0 || busy), 64'(0));
        for (int i = 0; i < NREQ; i++) chk("queue_empty", 64'(exp_q[i].size()), 64'(0));
    endtask

    initial begin
        int exp1 [6];
        int exp3 [11];
        int exp4 [14];
        int run;
        int max_run;

        for (int i = 0; i < NREQ; i++) begin
            remaining[i] = 0;
            seq[i] = 0;
        end

        // Single producer, three words then release.
        do_reset();
        remaining[0] = 3;
        present(0);
        for (int c = 0; c < 6; c++) tick();
        exp1 = '{-1, 0, 0, 0, -1, -1};
        for (int c = 0; c < 6; c++) chk("t1_cycle", 64'(cyc_log[c]), 64'(exp1[c]));
        chk("t1_busy_idle", 64'(busy), 64'(0));
        chk("t1_grant_id", 64'(grant_id), 64'(0));

        // All four requesting continuously: 0,1,2,3,0 with one idle cycle per burst.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            remaining[i] = 100;
            present(i);
        end
        for (int c = 0; c < 25; c++) tick();
        for (int c = 0; c < 25; c++)
            chk("t2_cycle", 64'(cyc_log[c]), 64'((c % 5 == 0) ? -1 : (c / 5) % 4));
        chk("t2_words_in_25", 64'(wr_log.size()), 64'(20));

        // FIFO full stall in the middle of requester 2's burst.
        do_reset();
        remaining[2] = 4;
        present(2);
        for (int c = 0; c < 3; c++) tick();
        fifo_full = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("t3_busy_stall", 64'(busy), 64'(1));
            chk("t3_data_held", 64'(fifo_wdata), 64'(exp_q[2][0]));
        end
        fifo_full = 1'b0;
        for (int c = 0; c < 3; c++) tick();
        exp3 = '{-1, 2, 2, -1, -1, -1, -1, -1, 2, 2, -1};
        for (int c = 0; c < 11; c++) chk("t3_cycle", 64'(cyc_log[c]), 64'(exp3[c]));
        chk("t3_words", 64'(wr_log.size()), 64'(4));
        chk("t3_no_dup", 64'(exp_q[2].size()), 64'(0));

        // Requesters 0 and 2 alternate; no burst longer than MAX_BURST.
        do_reset();
        remaining[0] = 10;
        remaining[2] = 4;
        present(0);
        present(2);
        drain(100);
        exp4 = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 0, 0, 0, 0};
        chk("t4_words", 64'(wr_log.size()), 64'(14));
        for (int c = 0; c < 14 && c < wr_log.size(); c++) chk("t4_order", 64'(wr_log[c]), 64'(exp4[c]));
        run = 0;
        max_run = 0;
        foreach (cyc_log[c]) begin
            run = (cyc_log[c] >= 0) ? run + 1 : 0;
            if (run > max_run) max_run = run;
        end
        chk("t4_max_consecutive", 64'(max_run), 64'(MAX_BURST));

        // Reset pulse at beat 2 of requester 2's burst while requester 1 is waiting.
        do_reset();
        remaining[2] = 8;
        present(2);
        for (int c = 0; c < 3; c++) tick();
        remaining[1] = 3;
        present(1);
        rst = 1'b1;
        #1;
        chk("t5_ack", 64'(ack), 64'(0));
        chk("t5_fifo_wr", 64'(fifo_wr), 64'(0));
        chk("t5_busy", 64'(busy), 64'(0));
        chk("t5_grant_id", 64'(grant_id), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc_log.delete();
        tick();
        tick();
        chk("t5_first_idle", 64'(cyc_log[0]), 64'(-1));
        chk("t5_first_grant", 64'(cyc_log[1]), 64'(1));
        drain(200);

        // Random requests and full flag with continuous invariants and ordered scoreboard.
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(0, 2) == 0) begin
                    remaining[i] = 1;
                    present(i);
                end
            end
            fifo_full = ($urandom_range(0, 3) == 0);
            tick();
        end
        fifo_full = 1'b0;
        drain(200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Round-robin write arbiter that shares one synchronous 32-bit FIFO write port between NREQ producers.
Each producer presents data with a req/ack handshake. The arbiter grants one producer at a time for a burst of up to MAX_BURST words and drives the FIFO wr/w_data inputs directly. The FIFO full flag is honoured, so no word is ever dropped or duplicated.

Parameters:
NREQ, 4, number of requesters (power of two, 2..8)
DW, 32, data width; matches FIFO w_data
MAX_BURST, 4, max words per grant before re-arbitration (1..16)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
req  input  NREQ  per-requester word-valid
data  input  NREQ*DW  requester i word in bits [i*DW +: DW]
ack  output  NREQ  per-requester word-accepted; one-hot or zero
fifo_wr  output  1  FIFO write strobe
fifo_wdata  output  DW  FIFO write data
fifo_full  input  1  FIFO full flag
grant_id  output  log2(NREQ)  index of current/last granted requester
busy  output  1  high while in BURST state

Behaviour:
- Reset (async, rst=1): state=IDLE, grant_id=0, last_ptr=NREQ-1 (requester 0 has first priority), beat_cnt=0.
  Under reset, ack, fifo_wr and busy are all 0; fifo_wdata is 0.
- Handshake: a word transfers in a cycle where req[i]=1 and ack[i]=1; the FIFO captures it on the same rising edge.
  - The requester holds req and data stable until ack.
  - req may deassert only after a transfer.
- ack, fifo_wr and fifo_wdata are combinational from registered state plus req/fifo_full:
  - in BURST: fifo_wr = req[grant_id] & ~fifo_full; ack[grant_id] = fifo_wr; fifo_wdata = data slice grant_id.
  - in IDLE: fifo_wr=0; ack=0; fifo_wdata=0.
- State IDLE:
  - if |req: pick the first i with req[i]=1, scanning from (last_ptr+1) mod NREQ upward with wrap.
  - on the same edge: grant_id<=i, last_ptr<=i, beat_cnt<=0, state<=BURST.
  - if no req: stay IDLE; grant_id holds.
- State BURST:
  - on transfer, beat_cnt<=beat_cnt+1.
  - transfer with beat_cnt==MAX_BURST-1 -> IDLE.
  - req[grant_id]=0 -> IDLE (no transfer that cycle).
  - fifo_full=1 with req high -> stay in BURST, no ack, beat_cnt holds; stalls indefinitely, no timeout.
- Latency: first ack no earlier than 1 cycle after req rises (one IDLE arbitration cycle).
  - Steady state: MAX_BURST words per MAX_BURST+1 cycles.
- Fairness: last_ptr updates only on grant. A requester with req held is granted within NREQ-1 intervening bursts.
- Requests from non-granted requesters during BURST are ignored until the next IDLE cycle.
- Only one ack bit is ever high, and only when fifo_wr=1. fifo_wr is never asserted while fifo_full=1.
- beat_cnt width is clog2(MAX_BURST)+1 and never exceeds MAX_BURST-1 while in BURST.
- Reset mid-burst: outputs drop immediately (combinational on state). The in-flight word is not written; the producer must re-present it after reset.

Test Plan:
- Reset release, req=0001, requester 0 presents 3 words A,B,C, then drops req -> IDLE 1 cycle.
  Then ack[0] and fifo_wr high for 3 consecutive cycles with fifo_wdata A,B,C, grant_id=0, then return to IDLE.
- req=1111 held with continuous data, MAX_BURST=4 -> grant order 0,1,2,3,0.
  Each burst is exactly 4 acks followed by 1 IDLE cycle; 20 words written in 25 cycles.
- Granted requester 2 sending words; fifo_full raised for 5 cycles after the 2nd word.
  -> fifo_wr=0 and ack=0 for those 5 cycles, data held. Burst resumes after fifo_full falls, words 3..4 are written, and there are no duplicates in the FIFO.
- req=0101, MAX_BURST=4, requester 0 streams 10 words -> requester 0 gets 4 words, requester 2 gets its burst, requester 0 gets 4 more.
  No requester exceeds 4 consecutive acks.
- rst pulsed for 1 cycle mid-burst at beat 2 -> ack, fifo_wr and busy are 0 immediately. After release, grant_id=0 and the first grant goes to the lowest-index active requester.
- Check all cycles under random req/full: ack never has more than one bit set, ack==0 whenever fifo_full=1, and FIFO contents equal the per-requester ordered streams.
